control_sequencer: RTL and testbench

//  - SAP-1 controller. Steps each instruction through machine states T1..T6 and decodes the

---
 rtl/sap_pkg.sv | 31 +++
 rtl/control_sequencer_if.sv | 28 ++
 rtl/t_state_ring.sv | 14 +
 rtl/control_sequencer.sv | 63 ++++++
 tb/tb_control_sequencer.sv | 123 ++++++++++++
 5 files changed

// File: rtl/sap_pkg.sv
// sap_pkg: shared SAP-1 opcodes, machine-state indices and control-word bit positions.
package sap_pkg;
  localparam int OPCODE_W = 4;
  localparam int NUM_T = 6;
  localparam logic [OPCODE_W-1:0] OP_LDA = 4'h0;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
  localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
  localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;
  localparam int T1 = 0;
  localparam int T2 = 1;
  localparam int T3 = 2;
  localparam int T4 = 3;
  localparam int T5 = 4;
  localparam int T6 = 5;
  localparam logic [NUM_T-1:0] ST_T1 = 6'b000001;
  localparam int CW_W = 12;
  localparam int CW_PC_OUT = 0;
  localparam int CW_PC_INC = 1;
  localparam int CW_MAR_LOAD = 2;
  localparam int CW_RAM_OUT = 3;
  localparam int CW_IR_LOAD = 4;
  localparam int CW_IR_SEND_ADDRESS = 5;
  localparam int CW_A_LOAD = 6;
  localparam int CW_A_OUT = 7;
  localparam int CW_B_LOAD = 8;
  localparam int CW_ALU_SUB = 9;
  localparam int CW_ALU_OUT = 10;
  localparam int CW_OUT_LOAD = 11;
  typedef logic [CW_W-1:0] cw_t;
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: opcode in, one-hot state and control word out of the SAP-1 sequencer.
interface control_sequencer_if;
  logic [sap_pkg::OPCODE_W-1:0] i_opcode;
  logic [sap_pkg::NUM_T-1:0] o_t_state;
  logic o_pc_out;
  logic o_pc_inc;
  logic o_mar_load;
  logic o_ram_out;
  logic o_ir_load;
  logic o_ir_send_address;
  logic o_a_load;
  logic o_a_out;
  logic o_b_load;
  logic o_alu_sub;
  logic o_alu_out;
  logic o_out_load;
  logic o_halted;
  modport master (
    input i_opcode,
    output o_t_state, o_pc_out, o_pc_inc, o_mar_load, o_ram_out, o_ir_load, o_ir_send_address,
           o_a_load, o_a_out, o_b_load, o_alu_sub, o_alu_out, o_out_load, o_halted
  );
  modport slave (
    output i_opcode,
    input o_t_state, o_pc_out, o_pc_inc, o_mar_load, o_ram_out, o_ir_load, o_ir_send_address,
          o_a_load, o_a_out, o_b_load, o_alu_sub, o_alu_out, o_out_load, o_halted
  );
endinterface

// File: rtl/t_state_ring.sv
// t_state_ring: one-hot T1..T6 ring counter with sync reset, hold and restart-to-T1.
module t_state_ring
  import sap_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic hold,
  input  logic restart,
  output logic [NUM_T-1:0] state
);
  always_ff @(posedge clk)
    if (rst) state <= ST_T1;
    else if (!hold) state <= restart ? ST_T1 : {state[NUM_T-2:0], state[NUM_T-1]};
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: SAP-1 T-state sequencer and control-word decode; CONTROL_SEQ_SKIP_NOP_EN ends instructions early.
module control_sequencer
  import sap_pkg::*;
(
  input logic i_clock,
  input logic i_reset,
  control_sequencer_if.master bus
);
  logic [NUM_T-1:0] t;
  logic halted;
  logic hlt_now;
  logic restart;
  logic is_lda, is_add, is_sub, is_out, is_hlt, mem_op, alu_op;
  cw_t cw;
  assign is_lda = bus.i_opcode == OP_LDA;
  assign is_add = bus.i_opcode == OP_ADD;
  assign is_sub = bus.i_opcode == OP_SUB;
  assign is_out = bus.i_opcode == OP_OUT;
  assign is_hlt = bus.i_opcode == OP_HLT;
  assign alu_op = is_add | is_sub;
  assign mem_op = is_lda | alu_op;
  assign hlt_now = t[T4] & is_hlt & ~halted;
`ifdef CONTROL_SEQ_SKIP_NOP_EN
  // Unknown opcodes are caught on the IR bus value at T3, before any execute state.
  assign restart = (t[T5] & is_lda) | (t[T4] & is_out) | (t[T3] & ~(mem_op | is_out | is_hlt));
`else
  assign restart = 1'b0;
`endif
  t_state_ring ring (.clk(i_clock), .rst(i_reset), .hold(halted | hlt_now), .restart(restart), .state(t));
  always_ff @(posedge i_clock)
    if (i_reset) halted <= 1'b0;
    else if (hlt_now) halted <= 1'b1;
  always_comb begin
    cw = '0;
    cw[CW_PC_OUT] = t[T1];
    cw[CW_PC_INC] = t[T2];
    cw[CW_MAR_LOAD] = t[T1] | (t[T4] & mem_op);
    cw[CW_RAM_OUT] = t[T3] | (t[T5] & mem_op);
    cw[CW_IR_LOAD] = t[T3];
    cw[CW_IR_SEND_ADDRESS] = t[T4] & mem_op;
    cw[CW_A_LOAD] = (t[T5] & is_lda) | (t[T6] & alu_op);
    cw[CW_A_OUT] = t[T4] & is_out;
    cw[CW_B_LOAD] = t[T5] & alu_op;
    cw[CW_ALU_SUB] = (t[T5] | t[T6]) & is_sub;
    cw[CW_ALU_OUT] = t[T6] & alu_op;
    cw[CW_OUT_LOAD] = t[T4] & is_out;
    if (i_reset || halted) cw = '0;
  end
  assign bus.o_t_state = t;
  assign bus.o_halted = halted;
  assign bus.o_pc_out = cw[CW_PC_OUT];
  assign bus.o_pc_inc = cw[CW_PC_INC];
  assign bus.o_mar_load = cw[CW_MAR_LOAD];
  assign bus.o_ram_out = cw[CW_RAM_OUT];
  assign bus.o_ir_load = cw[CW_IR_LOAD];
  assign bus.o_ir_send_address = cw[CW_IR_SEND_ADDRESS];
  assign bus.o_a_load = cw[CW_A_LOAD];
  assign bus.o_a_out = cw[CW_A_OUT];
  assign bus.o_b_load = cw[CW_B_LOAD];
  assign bus.o_alu_sub = cw[CW_ALU_SUB];
  assign bus.o_alu_out = cw[CW_ALU_OUT];
  assign bus.o_out_load = cw[CW_OUT_LOAD];
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: table-driven check of fetch/execute control words plus halt and mid-instruction reset sequences.
module tb_control_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  control_sequencer_if bus ();
  control_sequencer dut (.i_clock(clk), .i_reset(rst), .bus(bus));
  localparam logic [11:0] PC_OUT = 12'h001, PC_INC = 12'h002, MAR_LD = 12'h004, RAM_OUT = 12'h008;
  localparam logic [11:0] IR_LD = 12'h010, IR_ADR = 12'h020, A_LD = 12'h040, A_OUT = 12'h080;
  localparam logic [11:0] B_LD = 12'h100, ALU_SUB = 12'h200, ALU_OUT = 12'h400, OUT_LD = 12'h800;
  typedef struct {
    logic [3:0] op;
    logic [5:0] st;
    logic [11:0] cw;
  } vec_t;
  vec_t vecs[$];
  function automatic logic [11:0] cw_now();
    return {bus.o_out_load, bus.o_alu_out, bus.o_alu_sub, bus.o_b_load, bus.o_a_out, bus.o_a_load,
            bus.o_ir_send_address, bus.o_ir_load, bus.o_ram_out, bus.o_mar_load, bus.o_pc_inc, bus.o_pc_out};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic add(input logic [3:0] op, input logic [5:0] st, input logic [11:0] cw);
    vec_t v;
    v.op = op;
    v.st = st;
    v.cw = cw;
    vecs.push_back(v);
  endtask
  task automatic fetch(input logic [3:0] op);
    add(op, 6'b000001, PC_OUT | MAR_LD);
    add(op, 6'b000010, PC_INC);
    add(op, 6'b000100, RAM_OUT | IR_LD);
  endtask
  initial begin
    fetch(4'h0);
    add(4'h0, 6'b001000, IR_ADR | MAR_LD);
    add(4'h0, 6'b010000, RAM_OUT | A_LD);
`ifndef CONTROL_SEQ_SKIP_NOP_EN
    add(4'h0, 6'b100000, 12'h000);
`endif
    fetch(4'h1);
    add(4'h1, 6'b001000, IR_ADR | MAR_LD);
    add(4'h1, 6'b010000, RAM_OUT | B_LD);
    add(4'h1, 6'b100000, ALU_OUT | A_LD);
    fetch(4'h2);
    add(4'h2, 6'b001000, IR_ADR | MAR_LD);
    add(4'h2, 6'b010000, RAM_OUT | B_LD | ALU_SUB);
    add(4'h2, 6'b100000, ALU_OUT | A_LD | ALU_SUB);
    fetch(4'hE);
    add(4'hE, 6'b001000, A_OUT | OUT_LD);
`ifndef CONTROL_SEQ_SKIP_NOP_EN
    add(4'hE, 6'b010000, 12'h000);
    add(4'hE, 6'b100000, 12'h000);
`endif
    fetch(4'h5);
`ifndef CONTROL_SEQ_SKIP_NOP_EN
    add(4'h5, 6'b001000, 12'h000);
    add(4'h5, 6'b010000, 12'h000);
    add(4'h5, 6'b100000, 12'h000);
`endif
    bus.i_opcode = 4'h0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cw_1", cw_now(), 0);
    @(negedge clk);
    chk("rst_cw_2", cw_now(), 0);
    chk("rst_state", bus.o_t_state, 6'b000001);
    chk("rst_halted", bus.o_halted, 0);
    rst = 1'b0;
    foreach (vecs[i]) begin
      bus.i_opcode = vecs[i].op;
      #1;
      chk($sformatf("vec%0d_state", i), bus.o_t_state, vecs[i].st);
      chk($sformatf("vec%0d_cw", i), cw_now(), vecs[i].cw);
      @(negedge clk);
    end
    chk("after_table_state", bus.o_t_state, 6'b000001);
    bus.i_opcode = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    chk("hlt_t4_state", bus.o_t_state, 6'b001000);
    chk("hlt_t4_cw", cw_now(), 0);
    chk("hlt_t4_halted", bus.o_halted, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("halt_hold%0d", i), {bus.o_halted, bus.o_t_state, cw_now()}, {1'b1, 6'b001000, 12'h000});
    end
    rst = 1'b1;
    @(negedge clk);
    chk("halt_rst_state", bus.o_t_state, 6'b000001);
    chk("halt_rst_halted", bus.o_halted, 0);
    chk("halt_rst_cw", cw_now(), 0);
    rst = 1'b0;
    bus.i_opcode = 4'h1;
    repeat (4) @(negedge clk);
    #1;
    chk("add_t5_state", bus.o_t_state, 6'b010000);
    chk("add_t5_cw", cw_now(), RAM_OUT | B_LD);
    rst = 1'b1;
    #1;
    chk("midrst_cw", cw_now(), 0);
    @(negedge clk);
    chk("midrst_state", bus.o_t_state, 6'b000001);
    rst = 1'b0;
    #1;
    chk("refetch_t1_cw", cw_now(), PC_OUT | MAR_LD);
    @(negedge clk);
    chk("refetch_t2_state", bus.o_t_state, 6'b000010);
    chk("refetch_t2_cw", cw_now(), PC_INC);
    @(negedge clk);
    chk("refetch_t3_cw", cw_now(), RAM_OUT | IR_LD);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
